// File: rtl/sha3_padder_pkg.sv
// Shared definitions for the SHA-3 padder.
//   N            : absorb word width in bits (one Keccak lane)
//   DOMAIN_BYTE  : domain-separation byte merged after the message
//   PAD_END_BYTE : terminating bit of the pad10*1 rule (byte 7 of the last word)
//   state_t      : padder FSM states
// Build option: define SHA3_PAD_SHAKE_EN to select the SHAKE domain byte (0x1F).
// Without it, the SHA-3 domain byte (0x06) is used.
package pkg_sha3;

    localparam int N = 64;

    localparam logic [7:0] SHA3_DOMAIN_BYTE  = 8'h06;
    localparam logic [7:0] SHAKE_DOMAIN_BYTE = 8'h1F;
    localparam logic [7:0] PAD_END_BYTE      = 8'h80;

`ifdef SHA3_PAD_SHAKE_EN
    localparam logic [7:0] DOMAIN_BYTE = SHAKE_DOMAIN_BYTE;
`else
    localparam logic [7:0] DOMAIN_BYTE = SHA3_DOMAIN_BYTE;
`endif

    typedef enum logic [1:0] {
        IDLE,
        MSG,
        PAD,
        LAST
    } state_t;

endpackage

// File: rtl/sha3_padder_lane.sv
// sha3_pad_lane: combinational merge for a single absorb word.
// Keeps the lowest keep_bytes bytes of data, zeroes the rest, ORs the domain
// byte into byte dom_pos when dom_en is set, and ORs 0x80 into byte 7 when
// end_en is set. Both merges may hit byte 7 together (e.g. 0x86).
// Ports:
//   data       in  N  raw message word, little-endian byte lanes
//   keep_bytes in  4  number of low bytes to keep (0..8)
//   dom_en     in  1  merge domain byte
//   dom_pos    in  3  byte lane receiving the domain byte
//   end_en     in  1  merge the terminating 0x80 into byte 7
//   word       out N  padded word
module sha3_pad_lane
    import pkg_sha3::*;
(
    input  logic [N-1:0] data,
    input  logic [3:0]   keep_bytes,
    input  logic         dom_en,
    input  logic [2:0]   dom_pos,
    input  logic         end_en,
    output logic [N-1:0] word
);

    always_comb begin
        word = '0;
        for (int i = 0; i < N/8; i++) begin
            if (i < int'(keep_bytes)) begin
                word[8*i +: 8] = data[8*i +: 8];
            end
            if (dom_en && (dom_pos == 3'(i))) begin
                word[8*i +: 8] = word[8*i +: 8] | DOMAIN_BYTE;
            end
            if (end_en && (i == N/8 - 1)) begin
                word[8*i +: 8] = word[8*i +: 8] | PAD_END_BYTE;
            end
        end
    end

endmodule

// File: rtl/sha3_padder.sv
// sha3_padder: streams message words into the absorb buffer and appends the
// SHA-3/SHAKE padding (domain byte, zero fill, final 0x80) up to a full block.
// Message words pass through combinationally; padding words are generated
// while the FSM is in PAD. Build option SHA3_PAD_SHAKE_EN selects the SHAKE
// domain byte (see pkg_sha3).
// Ports:
//   clk, rst        clock / asynchronous active-high reset
//   start           begin a message (only honoured in IDLE)
//   msg_len_bytes   message length in bytes, captured with start
//   msg_in          message word, msg_in_valid / msg_in_ready handshake
//   buffer_full     downstream absorb buffer cannot take a word
//   word_out        padded word, qualified by word_out_valid
//   last_block      final block delivered, held until done
//   busy            FSM not idle
//   done            one-cycle completion pulse
module sha3_padder
    import pkg_sha3::*;
#(
    parameter int RATE = 1088
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [31:0]  msg_len_bytes,
    input  logic [N-1:0] msg_in,
    input  logic         msg_in_valid,
    output logic         msg_in_ready,
    input  logic         buffer_full,
    output logic [N-1:0] word_out,
    output logic         word_out_valid,
    output logic         last_block,
    output logic         busy,
    output logic         done
);

    localparam int WORDS = RATE / 64;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t           state, state_next;
    logic [31:0]      remaining, remaining_next;
    logic [IDX_W-1:0] word_idx;
    logic             dom_pending, dom_pending_next;
    logic             bf_prev;
    logic             consume;
    logic             last_word;
    logic             rem_partial;

    logic [N-1:0]     lane_data;
    logic [3:0]       lane_keep;
    logic             lane_dom_en;
    logic [2:0]       lane_dom_pos;
    logic             lane_end_en;
    logic [N-1:0]     lane_word;

    sha3_pad_lane u_lane (
        .data       (lane_data),
        .keep_bytes (lane_keep),
        .dom_en     (lane_dom_en),
        .dom_pos    (lane_dom_pos),
        .end_en     (lane_end_en),
        .word       (lane_word)
    );

    // Next-state and output decode. A word is consumed whenever it is valid
    // and the absorb buffer has room; all counters move only on consumption,
    // so a full buffer freezes word_out. A word with fewer than 8 bytes left
    // is the partial final word and carries the domain byte itself; a final
    // word of exactly 8 bytes leaves the domain byte pending for PAD.
    always_comb begin
        state_next       = state;
        remaining_next   = remaining;
        dom_pending_next = dom_pending;
        msg_in_ready     = 1'b0;
        word_out_valid   = 1'b0;
        word_out         = '0;
        consume          = 1'b0;
        lane_data        = '0;
        lane_keep        = 4'd0;
        lane_dom_en      = 1'b0;
        lane_dom_pos     = 3'd0;
        lane_end_en      = 1'b0;
        rem_partial      = (remaining < 32'd8);
        last_word        = (word_idx == LAST_IDX);

        case (state)
            IDLE: begin
                if (start) begin
                    remaining_next   = msg_len_bytes;
                    dom_pending_next = 1'b1;
                    state_next       = (msg_len_bytes == 32'd0) ? PAD : MSG;
                end
            end
            MSG: begin
                msg_in_ready   = ~buffer_full;
                word_out_valid = msg_in_valid;
                lane_data      = msg_in;
                lane_keep      = rem_partial ? {1'b0, remaining[2:0]} : 4'd8;
                lane_dom_en    = rem_partial;
                lane_dom_pos   = remaining[2:0];
                lane_end_en    = rem_partial && last_word;
                word_out       = lane_word;
                consume        = msg_in_valid && !buffer_full;
                if (consume) begin
                    if (rem_partial) begin
                        remaining_next   = 32'd0;
                        dom_pending_next = 1'b0;
                        state_next       = last_word ? LAST : PAD;
                    end else begin
                        remaining_next = remaining - 32'd8;
                        if (remaining == 32'd8) begin
                            state_next = PAD;
                        end
                    end
                end
            end
            PAD: begin
                word_out_valid = 1'b1;
                lane_dom_en    = dom_pending;
                lane_end_en    = last_word;
                word_out       = lane_word;
                consume        = !buffer_full;
                if (consume) begin
                    dom_pending_next = 1'b0;
                    if (last_word) begin
                        state_next = LAST;
                    end
                end
            end
            LAST: begin
                // The absorb buffer fills while it permutes; its release
                // marks the end of the message.
                if (bf_prev && !buffer_full) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, counters and the registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            remaining   <= 32'd0;
            word_idx    <= '0;
            dom_pending <= 1'b0;
            bf_prev     <= 1'b0;
            last_block  <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_next;
            remaining   <= remaining_next;
            dom_pending <= dom_pending_next;
            bf_prev     <= buffer_full;
            done        <= 1'b0;
            if (state == IDLE && start) begin
                word_idx <= '0;
            end else if (consume) begin
                word_idx <= last_word ? '0 : word_idx + IDX_W'(1);
            end
            if (consume && state_next == LAST) begin
                last_block <= 1'b1;
            end else if (state == LAST && state_next == IDLE) begin
                last_block <= 1'b0;
                done       <= 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
